mux_scan_sel: RTL and testbench
===============================

# mux_scan_sel

Parametrised N-channel, W-bit registered multiplexer with manual-select and automatic round-robin scan modes. Generalises the 8:1 single-bit combinational selector into a clocked block: registered output, output valid, selected-channel tag and scan wrap-around flag. It sits between a bank of parallel sources (switches, sensor lines, channel buses) and a single downstream consumer, such as a display driver or serialiser, that samples one channel at a time.

## Interface
- NCH, 8: number of input channels, 2..64; need not be a power of two.
- W, 1: width of each channel in bits, 1..32.
- DWELL, 4: cycles each channel is held in scan mode, 1..256.
- SELW (localparam): $clog2(NCH), minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i  in  NCH*W  packed channels; channel k is i[k*W +: W].
- s  in  SELW  manual channel select.
- mode  in  1  0 = manual, 1 = scan.
- en  in  1  block enable.
- y  out  W  registered selected data.
- y_ch  out  SELW  channel index that produced y.
- y_valid  out  1  y and y_ch are meaningful this cycle.
- wrap  out  1  one-cycle pulse when scan moves from NCH-1 to 0.

## Operation
- FSM states: IDLE, MANUAL, SCAN. Reset enters IDLE.
- IDLE: entered whenever en=0, from any state. Exits to MANUAL if mode=0, or to SCAN if mode=1, on the first cycle en=1.
- MANUAL to SCAN when mode=1. SCAN to MANUAL when mode=0. en=0 has priority over a mode change.
- MANUAL behaviour:
  - y <= channel s; y_ch <= s; y_valid <= 1.
  - If s >= NCH (out of range): y <= 0, y_ch <= s, y_valid <= 0. Never index outside i.
- SCAN behaviour:
  - Internal channel counter ch and dwell counter dc. Both clear to 0 on every entry to SCAN.
  - Each cycle: y <= channel ch, y_ch <= ch, y_valid <= 1.
  - dc counts 0..DWELL-1. When dc = DWELL-1, dc <= 0 and ch advances.
  - ch advances to ch+1, or to 0 when ch = NCH-1. The NCH-1 to 0 step also asserts wrap for that same cycle.
  - With DWELL=1, ch advances every cycle.
- IDLE behaviour: y and y_ch hold their last values; y_valid = 0; wrap = 0; ch and dc hold.
- Data path width: the result is exactly W bits; no sign handling.

## Timing
- Reset values: y=0, y_ch=0, y_valid=0, wrap=0, ch=0, dc=0, state=IDLE.
- Latency: one cycle. Inputs sampled at edge n appear on y, y_ch and y_valid after edge n.
- Entering a mode: the first valid output appears one cycle after the state transition edge. That transition cycle itself outputs y_valid=0, so consumers never see a stale channel as valid.
- Scan channel order: ch holds each value for exactly DWELL consecutive valid outputs.
- wrap is registered and aligns with the first output cycle of channel 0 after a wrap. It never asserts on initial entry to SCAN.
- Simultaneous rst and any other input: rst wins.
- Reset during scan: the next cycle is IDLE with all reset values, regardless of en and mode.
- Changes to i or s take effect on the following edge. There are no combinational paths from inputs to outputs.

## Structure
- Shared package or include file `mux_pkg`:
  - state encodings ST_IDLE, ST_MANUAL, ST_SCAN (2-bit);
  - mode constants MODE_MANUAL, MODE_SCAN.
- Natural sub-module: `scan_counter`, parametrised by NCH and DWELL.
  - Inputs: clk, rst, clr, run.
  - Outputs: ch, wrap_next.
  - Contains the dwell and channel counters plus wrap detection.
- The top level holds the FSM, the range check and the output registers. Channel selection uses an indexed part-select, not a priority loop.

## Test plan
- Reset: assert rst for 2 cycles with en=1, mode=1 -> y=0, y_ch=0, y_valid=0, wrap=0 during reset and on the first cycle after release (transition cycle).
- Manual: NCH=8, W=1, i=8'b1010_0110, en=1, mode=0; step s=0..7 -> after one cycle each, y = 0,1,1,0,0,1,0,1, y_ch=s, y_valid=1.
- Scan wrap: NCH=8, DWELL=4, W=1, i=8'hFF -> y_ch sequence 0×4, 1×4, …, 7×4, then 0; wrap=1 exactly on the first cycle of y_ch=0 after channel 7, and never at entry.
- Out of range: NCH=6, W=4, mode=0, s=7 -> y=0, y_ch=7, y_valid=0. Then s=5 -> y=i[23:20], y_valid=1 next cycle.
- Mode and enable interaction: in scan at ch=3, dc=2, set mode=0 with s=1 -> y_ch=1 from the cycle after the transition. Return to mode=1 -> scan restarts at ch=0. Drop en mid-scan -> y_valid=0, y held.
- Reset mid-scan: rst pulse at ch=5 -> next cycle is all reset values. After release with en=1, mode=1, scan restarts at ch=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the registered channel selector: FSM encodings,
// mode constants and a width helper for index buses.
package mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Index width for n items, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_counter.sv
// Round-robin channel counter with per-channel dwell; flags the step from the
// last channel back to channel 0 so the top can align wrap with channel 0 output.
module scan_counter
   import mux_pkg::*;
#(
   parameter  int NCH   = 8,
   parameter  int DWELL = 4,
   localparam int SELW  = width_of(NCH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            run,
   output logic [SELW-1:0] ch,
   output logic            wrap_next
);

   localparam int              DCW     = width_of(DWELL);
   localparam logic [DCW-1:0]  DC_LAST = DCW'(DWELL - 1);
   localparam logic [SELW-1:0] CH_LAST = SELW'(NCH - 1);

   logic [DCW-1:0]  dc_reg;
   logic [SELW-1:0] ch_reg;
   logic            wrap_pend_reg;
   logic            dwell_done;
   logic            ch_last;

   assign dwell_done = (dc_reg == DC_LAST);
   assign ch_last    = (ch_reg == CH_LAST);

   // wrap_pend_reg is set on the step into channel 0 and consumed by the next
   // run cycle, which is the one that presents channel 0 downstream.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         dc_reg        <= '0;
         ch_reg        <= '0;
         wrap_pend_reg <= 1'b0;
      end else if (run) begin
         wrap_pend_reg <= dwell_done && ch_last;
         if (dwell_done) begin
            dc_reg <= '0;
            ch_reg <= ch_last ? '0 : ch_reg + SELW'(1);
         end else begin
            dc_reg <= dc_reg + DCW'(1);
         end
      end
   end

   assign ch        = ch_reg;
   assign wrap_next = wrap_pend_reg;

endmodule

// File: rtl/mux_scan_sel.sv
// N-channel, W-bit registered selector with manual select and round-robin scan.
// Any state change produces one cycle with y_valid low before new data appears.
module mux_scan_sel
   import mux_pkg::*;
#(
   parameter  int NCH   = 8,
   parameter  int W     = 1,
   parameter  int DWELL = 4,
   localparam int SELW  = width_of(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH*W-1:0] i,
   input  logic [SELW-1:0]  s,
   input  logic             mode,
   input  logic             en,
   output logic [W-1:0]     y,
   output logic [SELW-1:0]  y_ch,
   output logic             y_valid,
   output logic             wrap
);

   localparam int BW = width_of(NCH * W);

   state_t          state_reg;
   logic            clr;
   logic            run;
   logic            s_ok;
   logic            wrap_next;
   logic [SELW-1:0] ch;
   logic [SELW-1:0] sel;
   logic [BW-1:0]   base;
   logic [W-1:0]    sel_data;

   assign s_ok = ({1'b0, s} < (SELW + 1)'(NCH));

   always_comb begin
      run = (state_reg == ST_SCAN) && en && (mode == MODE_SCAN);
      clr = (state_reg != ST_SCAN) && en && (mode == MODE_SCAN);
      sel = '0;
      if (state_reg == ST_SCAN)
         sel = ch;
      else if (s_ok)
         sel = s;
   end

   // Out-of-range selects are forced to channel 0 so the slice stays inside i.
   assign base     = BW'(sel) * BW'(W);
   assign sel_data = i[base +: W];

   scan_counter #(
      .NCH   (NCH),
      .DWELL (DWELL)
   ) u_scan_counter (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .run       (run),
      .ch        (ch),
      .wrap_next (wrap_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         y         <= '0;
         y_ch      <= '0;
         y_valid   <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         y_valid <= 1'b0;
         wrap    <= 1'b0;
         if (!en) begin
            state_reg <= ST_IDLE;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  state_reg <= (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
               end
               ST_MANUAL: begin
                  if (mode == MODE_SCAN) begin
                     state_reg <= ST_SCAN;
                  end else begin
                     y       <= s_ok ? sel_data : '0;
                     y_ch    <= s;
                     y_valid <= s_ok;
                  end
               end
               ST_SCAN: begin
                  if (mode == MODE_MANUAL) begin
                     state_reg <= ST_MANUAL;
                  end else begin
                     y       <= sel_data;
                     y_ch    <= ch;
                     y_valid <= 1'b1;
                     wrap    <= wrap_next;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench: an 8x1 scanner (DWELL=4) and a 6x4 scanner (DWELL=2),
// checked cycle by cycle against hand-computed values.
module tb_mux_scan_sel;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: NCH=8, W=1, DWELL=4
   logic       rst_a, mode_a, en_a;
   logic [7:0] i_a;
   logic [2:0] s_a;
   logic [0:0] y_a;
   logic [2:0] ych_a;
   logic       yv_a, wrap_a;

   // Instance B: NCH=6, W=4, DWELL=2
   logic        rst_b, mode_b, en_b;
   logic [23:0] i_b;
   logic [2:0]  s_b;
   logic [3:0]  y_b;
   logic [2:0]  ych_b;
   logic        yv_b, wrap_b;

   // Bits of 8'hA6, channel 0 first
   int exp_man[8] = '{0, 1, 1, 0, 0, 1, 0, 1};
   // Nibbles of 24'hF93C71, channel 0 first
   int exp_b[6]   = '{1, 7, 12, 3, 9, 15};

   mux_scan_sel #(.NCH(8), .W(1), .DWELL(4)) u_dut_a (
      .clk(clk), .rst(rst_a), .i(i_a), .s(s_a), .mode(mode_a), .en(en_a),
      .y(y_a), .y_ch(ych_a), .y_valid(yv_a), .wrap(wrap_a)
   );

   mux_scan_sel #(.NCH(6), .W(4), .DWELL(2)) u_dut_b (
      .clk(clk), .rst(rst_b), .i(i_b), .s(s_b), .mode(mode_b), .en(en_b),
      .y(y_b), .y_ch(ych_b), .y_valid(yv_b), .wrap(wrap_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic chk_a(input string t, input int ey, input int ech, input int ev, input int ew);
      chk({t, ".y"},     32'(y_a),    32'(ey));
      chk({t, ".y_ch"},  32'(ych_a),  32'(ech));
      chk({t, ".valid"}, 32'(yv_a),   32'(ev));
      chk({t, ".wrap"},  32'(wrap_a), 32'(ew));
   endtask

   task automatic chk_b(input string t, input int ey, input int ech, input int ev, input int ew);
      chk({t, ".y"},     32'(y_b),    32'(ey));
      chk({t, ".y_ch"},  32'(ych_b),  32'(ech));
      chk({t, ".valid"}, 32'(yv_b),   32'(ev));
      chk({t, ".wrap"},  32'(wrap_b), 32'(ew));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; en_a = 1'b1; mode_a = 1'b1; i_a = 8'hFF;     s_a = 3'd0;
      rst_b = 1'b1; en_b = 1'b1; mode_b = 1'b1; i_b = 24'hF93C71; s_b = 3'd0;

      // Reset held two cycles with en=1, mode=scan
      tick(); chk_a("a_rst1", 0, 0, 0, 0); chk_b("b_rst1", 0, 0, 0, 0);
      tick(); chk_a("a_rst2", 0, 0, 0, 0);
      rst_a = 1'b0;
      tick(); chk_a("a_entry", 0, 0, 0, 0);

      // Full scan pass plus wrap back to channel 0
      for (int k = 0; k <= 32; k++) begin
         tick();
         chk_a($sformatf("a_scan%0d", k), 1, (k / 4) % 8, 1, (k == 32) ? 1 : 0);
      end

      // Manual select over all channels
      mode_a = 1'b0; i_a = 8'hA6;
      tick(); chk("a_man_tr.valid", 32'(yv_a), 32'd0);
      for (int k = 0; k < 8; k++) begin
         s_a = 3'(k);
         tick(); chk_a($sformatf("a_man%0d", k), exp_man[k], k, 1, 0);
      end

      // Scan up to ch=3, dc=2, then switch to manual s=1
      mode_a = 1'b1;
      tick(); chk("a_scan_tr.valid", 32'(yv_a), 32'd0);
      for (int k = 0; k < 14; k++) begin
         tick(); chk_a($sformatf("a_rescan%0d", k), exp_man[k / 4], k / 4, 1, 0);
      end
      mode_a = 1'b0; s_a = 3'd1;
      tick(); chk("a_sw_man.valid", 32'(yv_a), 32'd0); chk("a_sw_man.y_ch", 32'(ych_a), 32'd3);
      tick(); chk_a("a_sw_man_out", 1, 1, 1, 0);
      mode_a = 1'b1;
      tick(); chk("a_sw_scan.valid", 32'(yv_a), 32'd0);
      tick(); chk_a("a_sw_scan_out", 0, 0, 1, 0);
      for (int k = 0; k < 4; k++) tick();
      chk_a("a_scan_ch1", 1, 1, 1, 0);

      // Drop enable: outputs hold, valid low, even with inputs changing
      en_a = 1'b0; i_a = 8'h00;
      tick(); chk_a("a_idle1", 1, 1, 0, 0);
      tick(); chk_a("a_idle2", 1, 1, 0, 0);
      en_a = 1'b1; i_a = 8'hA6;
      tick(); chk("a_reen.valid", 32'(yv_a), 32'd0);
      tick(); chk_a("a_reen_out", 0, 0, 1, 0);
      for (int j = 1; j <= 20; j++) begin
         tick(); chk_a($sformatf("a_run%0d", j), exp_man[j / 4], j / 4, 1, 0);
      end

      // Reset pulse while presenting channel 5
      rst_a = 1'b1;
      tick(); chk_a("a_midrst", 0, 0, 0, 0);
      rst_a = 1'b0;
      tick(); chk_a("a_postrst_tr", 0, 0, 0, 0);
      i_a = 8'hFF;
      tick(); chk_a("a_postrst_out", 1, 0, 1, 0);
      en_a = 1'b0;

      // Instance B: out-of-range select on a non-power-of-two bank
      rst_b = 1'b0; mode_b = 1'b0; s_b = 3'd7;
      tick(); chk("b_man_tr.valid", 32'(yv_b), 32'd0);
      tick(); chk_b("b_oor7", 0, 7, 0, 0);
      s_b = 3'd5;
      tick(); chk_b("b_s5", 15, 5, 1, 0);
      s_b = 3'd6;
      tick(); chk_b("b_oor6", 0, 6, 0, 0);
      s_b = 3'd2;
      tick(); chk_b("b_s2", 12, 2, 1, 0);

      // Instance B scan with wrap after channel 5
      mode_b = 1'b1;
      tick(); chk("b_scan_tr.valid", 32'(yv_b), 32'd0);
      for (int k = 0; k <= 12; k++) begin
         tick();
         chk_b($sformatf("b_scan%0d", k), exp_b[(k / 2) % 6], (k / 2) % 6, 1, (k == 12) ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
